// File: rtl/fsm_pkg.sv
// Shared definitions for the programmable sequence generator.
//   state_t    : FSM state encoding (RUN, HALT)
//   DIR_FWD/REV: values of the dir input
//   step_next  : next index for one step in a given direction; the wrap flag
//                comes back through an output argument
package fsm_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Returns the stepped index. wrap is set when the step crosses the
    // terminal entry for that direction.
    function automatic int step_next(input int idx, input logic dir,
                                     input int depth, output logic wrap);
        int nidx;
        wrap = 1'b0;
        if (dir == DIR_FWD) begin
            if (idx == depth - 1) begin
                nidx = 0;
                wrap = 1'b1;
            end else begin
                nidx = idx + 1;
            end
        end else begin
            if (idx == 0) begin
                nidx = depth - 1;
                wrap = 1'b1;
            end else begin
                nidx = idx - 1;
            end
        end
        return nidx;
    endfunction

endpackage

// File: rtl/fsm_seq_table.sv
// DEPTH x WIDTH sequence table.
//   clk, n_reset : clock and synchronous active-low reset (loads identity)
//   wr_en/wr_idx/wr_data : write port; out-of-range addresses are ignored
//   rd_idx/rd_data      : combinational read with same-cycle write bypass
module fsm_seq_table #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 6,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);
    import fsm_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = wr_en && (int'(wr_idx) < DEPTH);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
        end else if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Bypass lets the output register capture a write landing on the
    // index it is about to load.
    always_comb begin
        rd_data = '0;
        if (wr_ok && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end else if (int'(rd_idx) < DEPTH) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/fsm_seq_gen.sv
// Programmable sequence-stepping FSM.
//   clk, n_reset      : clock and synchronous active-low reset
//   step, dir         : advance one entry forward (dir=1) or reverse (dir=0)
//   one_shot          : halt at the terminal entry instead of wrapping
//   jump, jump_idx    : load the index directly (out of range -> 0)
//   wr_en/idx/data    : table write port
//   Q, idx            : registered code table[idx] and index
//   wrap              : one-cycle pulse after a wrap-around step
//   done              : high while halted
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | stepping enabled; terminal step wraps or halts per one_shot
// HALT  | parked at terminal entry; step ignored while one_shot=1
module fsm_seq_gen #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 6,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             step,
    input  logic             dir,
    input  logic             one_shot,
    input  logic             jump,
    input  logic [IDX_W-1:0] jump_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] Q,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             done
);
    import fsm_pkg::*;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx_next, idx_step;
    logic             wrap_next, step_wrap;
    logic [WIDTH-1:0] rd_data;

    fsm_seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (idx_next),
        .rd_data (rd_data)
    );

    always_comb begin
        step_wrap  = 1'b0;
        idx_step   = IDX_W'(step_next(int'(idx), dir, DEPTH, step_wrap));
        idx_next   = idx;
        state_next = state;
        wrap_next  = 1'b0;
        if (jump) begin
            idx_next   = (int'(jump_idx) < DEPTH) ? jump_idx : '0;
            state_next = RUN;
        end else if (step) begin
            if (state == RUN) begin
                // A terminal step under one_shot parks instead of wrapping.
                if (step_wrap && one_shot) begin
                    state_next = HALT;
                end else begin
                    idx_next  = idx_step;
                    wrap_next = step_wrap;
                end
            end else if (!one_shot) begin
                idx_next   = idx_step;
                wrap_next  = step_wrap;
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= RUN;
            idx   <= '0;
            Q     <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            Q     <= rd_data;
            wrap  <= wrap_next;
            done  <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: directed walk-through followed by random
// stimulus, checked against a behavioural model of the sequence table.
module tb_fsm_seq_gen;
    localparam int WIDTH = 3;
    localparam int DEPTH = 6;
    localparam int IDX_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             step = 1'b0, dir = 1'b1, one_shot = 1'b0, jump = 1'b0, wr_en = 1'b0;
    logic [IDX_W-1:0] jump_idx = '0, wr_idx = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] Q;
    logic [IDX_W-1:0] idx;
    logic             wrap, done;

    fsm_seq_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_reset(n_reset), .step(step), .dir(dir), .one_shot(one_shot),
        .jump(jump), .jump_idx(jump_idx), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .Q(Q), .idx(idx), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int ix;
        int wr;
        int dn;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int m_tbl [DEPTH];
    int m_idx  = 0;
    bit m_halt = 0;
    int m_wrap = 0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (int'(Q) != e.q || int'(idx) != e.ix || int'(wrap) != e.wr || int'(done) != e.dn) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: got Q=%0d idx=%0d wrap=%0d done=%0d, want Q=%0d idx=%0d wrap=%0d done=%0d",
                         $time, Q, idx, wrap, done, e.q, e.ix, e.wr, e.dn);
            end
        end
    end

    task automatic lit(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    // Apply one cycle of stimulus and push the model's view of the next state.
    task automatic cyc(input bit rst, input bit st, input bit d, input bit os,
                       input bit jp, input int jix, input bit we, input int wix, input int wd);
        exp_t e;
        bit   term;
        @(negedge clk);
        n_reset  = ~rst;
        step     = st;
        dir      = d;
        one_shot = os;
        jump     = jp;
        jump_idx = IDX_W'(jix);
        wr_en    = we;
        wr_idx   = IDX_W'(wix);
        wr_data  = WIDTH'(wd);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
            m_idx = 0; m_halt = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (jp) begin
                m_idx  = (jix < DEPTH) ? jix : 0;
                m_halt = 0;
            end else if (st && !(m_halt && os)) begin
                term = d ? (m_idx == DEPTH - 1) : (m_idx == 0);
                if (term && os) begin
                    m_halt = 1;
                end else begin
                    m_idx  = (m_idx + (d ? 1 : DEPTH - 1)) % DEPTH;
                    m_wrap = term;
                    m_halt = 0;
                end
            end
            if (we && wix < DEPTH) m_tbl[wix] = wd % (1 << WIDTH);
        end
        e.q  = m_tbl[m_idx];
        e.ix = m_idx;
        e.wr = m_wrap;
        e.dn = m_halt;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    int wtab [DEPTH] = '{0, 1, 3, 5, 7, 2};
    int fq   [DEPTH] = '{1, 3, 5, 7, 2, 0};

    initial begin
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        lit("reset_q", Q, 0);
        lit("reset_idx", idx, 0);
        lit("reset_done", done, 0);
        lit("reset_wrap", wrap, 0);

        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0, 0, 1, i, wtab[i]);

        for (int k = 0; k < DEPTH; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
            settle();
            lit("fwd_q", Q, fq[k]);
            lit("fwd_wrap", wrap, (k == DEPTH - 1) ? 1 : 0);
        end

        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        lit("rev_wrap_q", Q, 2);
        lit("rev_wrap_idx", idx, 5);
        lit("rev_wrap_flag", wrap, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        lit("rev_q", Q, 7);
        lit("rev_wrap_clear", wrap, 0);

        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
        settle();
        lit("os_idx5", idx, 5);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
        settle();
        lit("os_done", done, 1);
        lit("os_hold_idx", idx, 5);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
        settle();
        lit("halt_ignore_idx", idx, 5);
        lit("halt_ignore_wrap", wrap, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        settle();
        lit("halt_exit_idx", idx, 0);
        lit("halt_exit_wrap", wrap, 1);
        lit("halt_exit_done", done, 0);

        cyc(0, 1, 1, 0, 1, 3, 0, 0, 0);
        settle();
        lit("jump_idx", idx, 3);
        lit("jump_q", Q, 5);
        cyc(0, 0, 1, 0, 1, 7, 0, 0, 0);
        settle();
        lit("jump_oor", idx, 0);

        cyc(0, 0, 1, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 1, 2, 6);
        settle();
        lit("bypass_q", Q, 6);
        cyc(0, 0, 1, 0, 0, 0, 1, 6, 4);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);

        cyc(1, 1, 1, 0, 0, 0, 1, 0, 7);
        settle();
        lit("midrst_q", Q, 0);
        lit("midrst_idx", idx, 0);
        for (int k = 0; k < DEPTH; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
            settle();
            lit("ident_q", Q, (k + 1) % DEPTH);
        end

        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(1) == 1), ($urandom_range(1) == 1),
                ($urandom_range(3) == 0), ($urandom_range(9) == 0), $urandom_range((1 << IDX_W) - 1),
                ($urandom_range(3) == 0), $urandom_range((1 << IDX_W) - 1),
                $urandom_range((1 << WIDTH) - 1));
        end

        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
